// File: rtl/sine_cfg_ctrl_if.sv
// Byte-stream handshake between the UART RX/TX blocks and the config controller.
// master: UART side (delivers rx bytes, accepts tx bytes)
// slave:  controller side
interface sine_cfg_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data
    );
endinterface

// File: rtl/sine_cfg_ctrl.sv
// UART command controller for the PWM sine generator.
// Parses 3-byte frames (0xA5, cmd, data), updates phase_step / amplitude /
// out_en and returns one response byte per completed frame.
module sine_cfg_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  PHASE_RST      = 8'h01,
    parameter logic [7:0]  AMP_RST        = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sine_cfg_ctrl_if.slave       bus,
    output logic [7:0]           phase_step,
    output logic [7:0]           amplitude,
    output logic                 out_en,
    output logic                 cfg_update
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [7:0] CMD_PHASE = 8'h01;
    localparam logic [7:0] CMD_AMP   = 8'h02;
    localparam logic [7:0] CMD_EN    = 8'h03;
    localparam logic [7:0] CMD_STAT  = 8'h04;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        RESP
    } state_t;

    state_t           state;
    logic [7:0]       cmd_reg;
    logic [CNT_W-1:0] tmo_cnt;
    logic             overrun;
    logic             timeout_seen;
    logic             tmo_hit;

    // Idle gap has lasted TIMEOUT_CYCLES edges once the counter shows CNT_LAST
    // on an edge without a byte; saturating compare avoids any wrap.
    always_comb begin
        tmo_hit = (tmo_cnt >= CNT_LAST);
    end

    // Frame parser, register writes, response generation and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_reg      <= '0;
            tmo_cnt      <= '0;
            overrun      <= 1'b0;
            timeout_seen <= 1'b0;
            phase_step   <= PHASE_RST;
            amplitude    <= AMP_RST;
            out_en       <= 1'b0;
            cfg_update   <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
        end else begin
            cfg_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state   <= CMD;
                        tmo_cnt <= '0;
                    end
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        tmo_cnt <= '0;
                        // A repeated sync byte restarts the frame instead of
                        // being taken as a command.
                        if (bus.rx_data != SYNC_BYTE) begin
                            cmd_reg <= bus.rx_data;
                            state   <= DATA;
                        end
                    end else if (tmo_hit) begin
                        state        <= IDLE;
                        timeout_seen <= 1'b1;
                        tmo_cnt      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        tmo_cnt      <= '0;
                        state        <= RESP;
                        bus.tx_valid <= 1'b1;
                        case (cmd_reg)
                            CMD_PHASE: begin
                                phase_step  <= (bus.rx_data == 8'h00) ? 8'h01 : bus.rx_data;
                                cfg_update  <= 1'b1;
                                bus.tx_data <= ACK_BYTE;
                            end
                            CMD_AMP: begin
                                amplitude   <= bus.rx_data;
                                cfg_update  <= 1'b1;
                                bus.tx_data <= ACK_BYTE;
                            end
                            CMD_EN: begin
                                out_en      <= bus.rx_data[0];
                                cfg_update  <= 1'b1;
                                bus.tx_data <= ACK_BYTE;
                            end
                            CMD_STAT: begin
                                // Status reports the flags as they were, then clears them.
                                bus.tx_data  <= {overrun, timeout_seen, 5'b0, out_en};
                                overrun      <= 1'b0;
                                timeout_seen <= 1'b0;
                            end
                            default: begin
                                bus.tx_data <= NAK_BYTE;
                            end
                        endcase
                    end else if (tmo_hit) begin
                        state        <= IDLE;
                        timeout_seen <= 1'b1;
                        tmo_cnt      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    // Bytes arriving while a response is pending are dropped,
                    // including one on the transfer edge itself.
                    if (bus.rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (bus.tx_valid && bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sine_cfg_ctrl.sv
// Self-checking bench for sine_cfg_ctrl: directed frame sequences, a table of
// single-frame vectors, and a randomized byte stream against a frame-level model.
module tb_sine_cfg_ctrl;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] phase_step;
    logic [7:0] amplitude;
    logic       out_en;
    logic       cfg_update;

    sine_cfg_ctrl_if bus ();

    sine_cfg_ctrl #(
        .TIMEOUT_CYCLES (TMO),
        .PHASE_RST      (8'h01),
        .AMP_RST        (8'hFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .phase_step (phase_step),
        .amplitude  (amplitude),
        .out_en     (out_en),
        .cfg_update (cfg_update)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cfg_pulses = 0;
    logic [7:0] rsp_q[$];

    // Collect completed tx transfers and count cfg_update pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) rsp_q.push_back(bus.tx_data);
            if (cfg_update === 1'b1) cfg_pulses++;
        end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rsp;
        logic [7:0] ph;
        logic [7:0] amp;
        logic       en;
        int         pulses;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        step();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(d);
    endtask

    task automatic wait_resp(input string name, input logic [7:0] exp);
        int n = 0;
        while (rsp_q.size() == 0 && n < 40) begin
            step();
            n++;
        end
        if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no response byte within 40 cycles, expected 0x%0h", name, exp);
        end else begin
            chk(name, rsp_q.pop_front(), exp);
        end
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        rst_n        = 1'b0;
        idle(2);
        rst_n = 1'b1;
        step();
        rsp_q.delete();
        cfg_pulses = 0;
    endtask

    initial begin
        int         p0;
        int         bad;
        int         m_got;
        logic [7:0] m_cmd;
        logic [7:0] m_ph;
        logic [7:0] m_amp;
        logic       m_en;
        int         m_pulses;
        logic [7:0] b;
        logic [7:0] exp_rsp;
        bit         done;

        // Reset state
        do_reset();
        chk("rst_phase", phase_step, 8'h01);
        chk("rst_amp", amplitude, 8'hFF);
        chk("rst_en", out_en, 1'b0);
        chk("rst_txv", bus.tx_valid, 1'b0);
        chk("rst_txd", bus.tx_data, 8'h00);
        chk("rst_cfg", cfg_update, 1'b0);

        // Write amplitude with cycle-level timing checks
        send_byte(8'hA5);
        send_byte(8'h02);
        chk("amp_before_data", amplitude, 8'hFF);
        send_byte(8'h80);
        chk("amp_after_data", amplitude, 8'h80);
        chk("cfg_pulse_hi", cfg_update, 1'b1);
        chk("txv_latency", bus.tx_valid, 1'b1);
        chk("txd_ack", bus.tx_data, 8'h06);
        step();
        chk("cfg_pulse_lo", cfg_update, 1'b0);
        chk("txv_drop", bus.tx_valid, 1'b0);
        wait_resp("rsp_amp", 8'h06);
        // back-to-back: sync lands the cycle after the transfer edge
        send_frame(8'h01, 8'h00);
        wait_resp("rsp_phase_clamp", 8'h06);
        chk("phase_clamp", phase_step, 8'h01);
        chk("two_pulses", cfg_pulses, 2);

        // Garbage, double sync, unknown command
        p0 = cfg_pulses;
        send_byte(8'h33);
        send_byte(8'hA5);
        send_frame(8'h07, 8'h11);
        wait_resp("rsp_nak", 8'h15);
        chk("nak_phase", phase_step, 8'h01);
        chk("nak_amp", amplitude, 8'h80);
        chk("nak_en", out_en, 1'b0);
        chk("nak_pulses", cfg_pulses, p0);

        // Backpressure with a byte dropped during RESP
        bus.tx_ready = 1'b0;
        send_frame(8'h03, 8'h01);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) send_byte(8'h55);
            else step();
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h06) bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        chk("bp_no_transfer", rsp_q.size(), 0);
        chk("bp_en", out_en, 1'b1);
        bus.tx_ready = 1'b1;
        wait_resp("rsp_bp", 8'h06);
        send_frame(8'h04, 8'h00);
        wait_resp("stat_overrun", 8'h81);
        send_frame(8'h04, 8'h00);
        wait_resp("stat_cleared", 8'h01);

        // Byte on the transfer edge counts as overrun and is dropped
        send_frame(8'h03, 8'h00);
        send_byte(8'hA5);
        wait_resp("rsp_edge", 8'h06);
        send_byte(8'h04);
        send_byte(8'h00);
        idle(3);
        chk("edge_sync_dropped", rsp_q.size(), 0);
        send_frame(8'h04, 8'h00);
        wait_resp("stat_edge_ovr", 8'h80);

        // Gap shorter than the timeout keeps the frame alive
        send_byte(8'hA5);
        send_byte(8'h02);
        idle(TMO - 2);
        send_byte(8'h44);
        wait_resp("rsp_short_gap", 8'h06);
        chk("short_gap_amp", amplitude, 8'h44);

        // Timeout abandons the frame without a response
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(TMO);
        chk("tmo_no_txv", bus.tx_valid, 1'b0);
        send_byte(8'h22);
        idle(3);
        chk("tmo_no_rsp", rsp_q.size(), 0);
        chk("tmo_phase", phase_step, 8'h01);
        send_frame(8'h04, 8'h00);
        wait_resp("stat_timeout", 8'h40);

        // Asynchronous reset in the middle of a frame
        send_frame(8'h01, 8'h37);
        wait_resp("rsp_pre_rst_ph", 8'h06);
        send_frame(8'h03, 8'h01);
        wait_resp("rsp_pre_rst_en", 8'h06);
        send_byte(8'hA5);
        send_byte(8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase", phase_step, 8'h01);
        chk("arst_amp", amplitude, 8'hFF);
        chk("arst_en", out_en, 1'b0);
        chk("arst_txv", bus.tx_valid, 1'b0);
        chk("arst_cfg", cfg_update, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        rsp_q.delete();
        send_frame(8'h02, 8'h80);
        wait_resp("post_rst_rsp", 8'h06);
        chk("post_rst_amp", amplitude, 8'h80);
        send_frame(8'h04, 8'h00);
        wait_resp("post_rst_stat", 8'h00);

        // Table of single frames, expectations accumulate from reset
        tbl[0]  = '{8'h02, 8'h80, 8'h06, 8'h01, 8'h80, 1'b0, 1};
        tbl[1]  = '{8'h01, 8'h00, 8'h06, 8'h01, 8'h80, 1'b0, 1};
        tbl[2]  = '{8'h01, 8'h10, 8'h06, 8'h10, 8'h80, 1'b0, 1};
        tbl[3]  = '{8'h01, 8'h20, 8'h06, 8'h20, 8'h80, 1'b0, 1};
        tbl[4]  = '{8'h07, 8'h11, 8'h15, 8'h20, 8'h80, 1'b0, 0};
        tbl[5]  = '{8'h03, 8'h01, 8'h06, 8'h20, 8'h80, 1'b1, 1};
        tbl[6]  = '{8'h04, 8'h00, 8'h01, 8'h20, 8'h80, 1'b1, 0};
        tbl[7]  = '{8'h03, 8'hFE, 8'h06, 8'h20, 8'h80, 1'b0, 1};
        tbl[8]  = '{8'h02, 8'hA5, 8'h06, 8'h20, 8'hA5, 1'b0, 1};
        tbl[9]  = '{8'h04, 8'h33, 8'h00, 8'h20, 8'hA5, 1'b0, 0};
        tbl[10] = '{8'h00, 8'h00, 8'h15, 8'h20, 8'hA5, 1'b0, 0};
        tbl[11] = '{8'h05, 8'h09, 8'h15, 8'h20, 8'hA5, 1'b0, 0};
        tbl[12] = '{8'h03, 8'h03, 8'h06, 8'h20, 8'hA5, 1'b1, 1};
        tbl[13] = '{8'h02, 8'h00, 8'h06, 8'h20, 8'h00, 1'b1, 1};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            p0 = cfg_pulses;
            send_frame(tbl[i].cmd, tbl[i].data);
            wait_resp($sformatf("tbl%0d_rsp", i), tbl[i].rsp);
            chk($sformatf("tbl%0d_phase", i), phase_step, tbl[i].ph);
            chk($sformatf("tbl%0d_amp", i), amplitude, tbl[i].amp);
            chk($sformatf("tbl%0d_en", i), out_en, tbl[i].en);
            chk($sformatf("tbl%0d_pulses", i), cfg_pulses - p0, tbl[i].pulses);
        end

        // Random byte stream against a frame-level model
        do_reset();
        m_got    = 0;
        m_cmd    = 8'h00;
        m_ph     = 8'h01;
        m_amp    = 8'hFF;
        m_en     = 1'b0;
        m_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: b = 8'hA5;
                4, 5, 6:    b = 8'($urandom_range(0, 5));
                default:    b = 8'($urandom_range(0, 255));
            endcase
            done    = 1'b0;
            exp_rsp = 8'h00;
            if (m_got == 0) begin
                if (b == 8'hA5) m_got = 1;
            end else if (m_got == 1) begin
                if (b != 8'hA5) begin
                    m_cmd = b;
                    m_got = 2;
                end
            end else begin
                done  = 1'b1;
                m_got = 0;
                if (m_cmd == 8'h01) begin
                    m_ph = (b == 8'h00) ? 8'h01 : b;
                    exp_rsp = 8'h06;
                    m_pulses++;
                end else if (m_cmd == 8'h02) begin
                    m_amp = b;
                    exp_rsp = 8'h06;
                    m_pulses++;
                end else if (m_cmd == 8'h03) begin
                    m_en = b[0];
                    exp_rsp = 8'h06;
                    m_pulses++;
                end else if (m_cmd == 8'h04) begin
                    exp_rsp = {7'b0, m_en};
                end else begin
                    exp_rsp = 8'h15;
                end
            end
            send_byte(b);
            if (done) begin
                wait_resp($sformatf("rnd%0d_rsp", i), exp_rsp);
                chk($sformatf("rnd%0d_phase", i), phase_step, m_ph);
                chk($sformatf("rnd%0d_amp", i), amplitude, m_amp);
                chk($sformatf("rnd%0d_en", i), out_en, m_en);
            end
            idle($urandom_range(0, 3));
        end
        idle(3);
        chk("rnd_pulses", cfg_pulses, m_pulses);
        chk("rnd_no_extra_rsp", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
